// File: rtl/clock_step_controller.sv
// clock_step_controller
// Run/halt/single-step scheduler for the processor clock divider. It counts
// the fast input clock and emits one-cycle read and write phase strobes, one
// of each per processor cycle, with a period that can be changed at runtime.
//
// Ports:
//   clock_in    - single rising-edge clock for all logic
//   reset_n     - asynchronous active-low reset
//   run         - level; requests free-running processor cycles
//   step        - level; a rising edge requests exactly one processor cycle
//   div_load    - one-cycle request to change the divisor
//   div_value   - new divisor, sampled when div_load is high
//   div_ack     - one-cycle pulse after a new divisor takes effect
//   div_err     - one-cycle pulse after a rejected load (div_value < 2)
//   tick_read   - read-phase strobe (counter == 0)
//   tick_write  - write-phase strobe (counter == div >> 1)
//   running     - high whenever the scheduler is not halted
module clock_step_controller #(
  parameter int WIDTH       = 28,
  parameter int DEFAULT_DIV = 4
) (
  input  logic             clock_in,
  input  logic             reset_n,
  input  logic             run,
  input  logic             step,
  input  logic             div_load,
  input  logic [WIDTH-1:0] div_value,
  output logic             div_ack,
  output logic             div_err,
  output logic             tick_read,
  output logic             tick_write,
  output logic             running
);

  typedef enum logic [1:0] {
    ST_HALT = 2'd0,
    ST_RUN  = 2'd1,
    ST_STEP = 2'd2
  } state_e;

  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
  localparam logic [WIDTH-1:0] TWO     = WIDTH'(2);
  localparam logic [WIDTH-1:0] DIV_RST = WIDTH'(DEFAULT_DIV);

  // Write-phase position inside a period: floor(div / 2).
  function automatic logic [WIDTH-1:0] half_period(input logic [WIDTH-1:0] d);
    return {1'b0, d[WIDTH-1:1]};
  endfunction

  state_e           state_q,      state_d;
  logic [WIDTH-1:0] counter_q,    counter_d;
  logic [WIDTH-1:0] div_q,        div_d;
  logic [WIDTH-1:0] pend_div_q,   pend_div_d;
  logic             pend_valid_q, pend_valid_d;
  logic             step_q;
  logic             div_ack_q,    div_ack_d;
  logic             div_err_q,    div_err_d;

  logic step_edge_s;
  logic active_s;
  logic boundary_s;
  logic apply_s;
  logic load_ok_s;
  logic load_bad_s;

  assign step_edge_s = step & ~step_q;
  assign active_s    = (state_q != ST_HALT);
  // Last cycle of a period; the counter never exceeds div-1.
  assign boundary_s  = active_s & (counter_q == (div_q - ONE));
  // Divisor changes only while halted or on a period boundary.
  assign apply_s     = (state_q == ST_HALT) | boundary_s;
  assign load_ok_s   = div_load & (div_value >= TWO);
  assign load_bad_s  = div_load & (div_value < TWO);

  // Scheduler next-state and cycle counter.
  always_comb begin
    state_d   = state_q;
    counter_d = counter_q;
    case (state_q)
      ST_HALT: begin
        counter_d = '0;
        // run wins over a coincident step edge
        if (run) begin
          state_d = ST_RUN;
        end else if (step_edge_s) begin
          state_d = ST_STEP;
        end else begin
          state_d = ST_HALT;
        end
      end
      ST_RUN: begin
        if (boundary_s) begin
          counter_d = '0;
          // run is only looked at on the boundary so a period is never cut short
          if (run) begin
            state_d = ST_RUN;
          end else begin
            state_d = ST_HALT;
          end
        end else begin
          counter_d = counter_q + ONE;
        end
      end
      ST_STEP: begin
        if (boundary_s) begin
          counter_d = '0;
          state_d   = ST_HALT;
        end else begin
          counter_d = counter_q + ONE;
        end
      end
      default: begin
        counter_d = '0;
        state_d   = ST_HALT;
      end
    endcase
  end

  // Divisor load, pending slot and acknowledge/error pulses.
  always_comb begin
    div_d        = div_q;
    pend_div_d   = pend_div_q;
    pend_valid_d = pend_valid_q;
    div_ack_d    = 1'b0;
    div_err_d    = load_bad_s;
    if (apply_s && pend_valid_q) begin
      div_d        = pend_div_q;
      pend_valid_d = 1'b0;
      div_ack_d    = 1'b1;
    end else begin
      div_ack_d    = 1'b0;
    end
    // A load coinciding with an apply lands in the slot after the older value
    // has been consumed, so it waits for the next apply point.
    if (load_ok_s) begin
      pend_div_d   = div_value;
      pend_valid_d = 1'b1;
    end else begin
      pend_div_d   = pend_div_d;
    end
  end

  // State, counter, divisor and pulse registers.
  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_HALT;
      counter_q    <= '0;
      div_q        <= DIV_RST;
      pend_div_q   <= DIV_RST;
      pend_valid_q <= 1'b0;
      step_q       <= 1'b0;
      div_ack_q    <= 1'b0;
      div_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      counter_q    <= counter_d;
      div_q        <= div_d;
      pend_div_q   <= pend_div_d;
      pend_valid_q <= pend_valid_d;
      step_q       <= step;
      div_ack_q    <= div_ack_d;
      div_err_q    <= div_err_d;
    end
  end

  assign running    = active_s;
  assign tick_read  = active_s & (counter_q == '0);
  assign tick_write = active_s & (counter_q == half_period(div_q));
  assign div_ack    = div_ack_q;
  assign div_err    = div_err_q;

endmodule

// File: tb/tb_clock_step_controller.sv
// Directed bench for clock_step_controller (WIDTH=28, DEFAULT_DIV=4).
// Each table row gives the inputs driven before a clock edge and the outputs
// expected in the cycle that follows; outputs are packed as
// {tick_read, tick_write, running, div_ack, div_err}.
module tb_clock_step_controller;

  logic        clk;
  logic        reset_n;
  logic        run;
  logic        step;
  logic        div_load;
  logic [27:0] div_value;
  logic        div_ack;
  logic        div_err;
  logic        tick_read;
  logic        tick_write;
  logic        running;

  int checks;
  int errors;

  clock_step_controller #(.WIDTH(28), .DEFAULT_DIV(4)) dut (
    .clock_in   (clk),
    .reset_n    (reset_n),
    .run        (run),
    .step       (step),
    .div_load   (div_load),
    .div_value  (div_value),
    .div_ack    (div_ack),
    .div_err    (div_err),
    .tick_read  (tick_read),
    .tick_write (tick_write),
    .running    (running)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        run;
    logic        step;
    logic        ld;
    logic [27:0] val;
    logic [4:0]  exp;
  } vec_t;

  vec_t vecs[$];

  localparam logic [4:0] E_0   = 5'b00000;
  localparam logic [4:0] E_RN  = 5'b00100;
  localparam logic [4:0] E_RD  = 5'b10100;
  localparam logic [4:0] E_WR  = 5'b01100;
  localparam logic [4:0] E_RDA = 5'b10110;
  localparam logic [4:0] E_ACK = 5'b00010;
  localparam logic [4:0] E_ERR = 5'b00001;

  function automatic void add(input logic r, input logic s, input logic l,
                              input logic [27:0] v, input logic [4:0] e);
    vec_t t;
    t.run = r; t.step = s; t.ld = l; t.val = v; t.exp = e;
    vecs.push_back(t);
  endfunction

  function automatic logic [4:0] obs();
    return {tick_read, tick_write, running, div_ack, div_err};
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  int cnt;

  initial begin
    checks = 0; errors = 0;
    reset_n = 1'b0; run = 1'b0; step = 1'b0; div_load = 1'b0; div_value = 28'd0;

    // free run, DIV=4: read at 1,5,9 write at 3,7,11; drop run at counter 2
    add(1'b1,1'b0,1'b0,28'd0,E_RD);  add(1'b1,1'b0,1'b0,28'd0,E_RN);
    add(1'b1,1'b0,1'b0,28'd0,E_WR);  add(1'b1,1'b0,1'b0,28'd0,E_RN);
    add(1'b1,1'b0,1'b0,28'd0,E_RD);  add(1'b1,1'b0,1'b0,28'd0,E_RN);
    add(1'b1,1'b0,1'b0,28'd0,E_WR);  add(1'b1,1'b0,1'b0,28'd0,E_RN);
    add(1'b1,1'b0,1'b0,28'd0,E_RD);  add(1'b1,1'b0,1'b0,28'd0,E_RN);
    add(1'b1,1'b0,1'b0,28'd0,E_WR);  add(1'b0,1'b0,1'b0,28'd0,E_RN);
    add(1'b0,1'b0,1'b0,28'd0,E_0);
    // single step; the second step edge at cycle 2 is ignored
    add(1'b0,1'b1,1'b0,28'd0,E_RD);  add(1'b0,1'b0,1'b0,28'd0,E_RN);
    add(1'b0,1'b1,1'b0,28'd0,E_WR);  add(1'b0,1'b0,1'b0,28'd0,E_RN);
    add(1'b0,1'b0,1'b0,28'd0,E_0);   add(1'b0,1'b0,1'b0,28'd0,E_0);
    // rejected loads 1 and 0
    add(1'b0,1'b0,1'b1,28'd1,E_ERR); add(1'b0,1'b0,1'b1,28'd0,E_ERR);
    add(1'b0,1'b0,1'b0,28'd0,E_0);
    // DIV=4 period still in force, load 6 mid-period
    add(1'b1,1'b0,1'b0,28'd0,E_RD);  add(1'b1,1'b0,1'b0,28'd0,E_RN);
    add(1'b1,1'b0,1'b1,28'd6,E_WR);  add(1'b1,1'b0,1'b0,28'd0,E_RN);
    add(1'b1,1'b0,1'b0,28'd0,E_RDA); add(1'b1,1'b0,1'b0,28'd0,E_RN);
    add(1'b1,1'b0,1'b0,28'd0,E_RN);  add(1'b1,1'b0,1'b0,28'd0,E_WR);
    add(1'b1,1'b0,1'b0,28'd0,E_RN);  add(1'b1,1'b0,1'b0,28'd0,E_RN);
    add(1'b1,1'b0,1'b0,28'd0,E_RD);  add(1'b0,1'b0,1'b0,28'd0,E_RN);
    add(1'b0,1'b0,1'b0,28'd0,E_RN);  add(1'b0,1'b0,1'b0,28'd0,E_WR);
    add(1'b0,1'b0,1'b0,28'd0,E_RN);  add(1'b0,1'b0,1'b0,28'd0,E_RN);
    add(1'b0,1'b0,1'b0,28'd0,E_0);
    // load 5 while halted, then run and drop run at counter 2
    add(1'b0,1'b0,1'b1,28'd5,E_0);   add(1'b0,1'b0,1'b0,28'd0,E_ACK);
    add(1'b1,1'b0,1'b0,28'd0,E_RD);  add(1'b1,1'b0,1'b0,28'd0,E_RN);
    add(1'b1,1'b0,1'b0,28'd0,E_WR);  add(1'b0,1'b0,1'b0,28'd0,E_RN);
    add(1'b0,1'b0,1'b0,28'd0,E_RN);  add(1'b0,1'b0,1'b0,28'd0,E_0);
    add(1'b0,1'b0,1'b0,28'd0,E_0);
    // load 6 mid-period, load 8 on the same edge that applies 6
    add(1'b1,1'b0,1'b0,28'd0,E_RD);  add(1'b1,1'b0,1'b1,28'd6,E_RN);
    add(1'b1,1'b0,1'b0,28'd0,E_WR);  add(1'b1,1'b0,1'b0,28'd0,E_RN);
    add(1'b1,1'b0,1'b0,28'd0,E_RN);  add(1'b1,1'b0,1'b1,28'd8,E_RDA);
    add(1'b1,1'b0,1'b0,28'd0,E_RN);  add(1'b1,1'b0,1'b0,28'd0,E_RN);
    add(1'b1,1'b0,1'b0,28'd0,E_WR);  add(1'b1,1'b0,1'b0,28'd0,E_RN);
    add(1'b1,1'b0,1'b0,28'd0,E_RN);  add(1'b1,1'b0,1'b0,28'd0,E_RDA);
    add(1'b1,1'b0,1'b0,28'd0,E_RN);  add(1'b1,1'b0,1'b0,28'd0,E_RN);
    add(1'b1,1'b0,1'b0,28'd0,E_RN);  add(1'b1,1'b0,1'b0,28'd0,E_WR);
    add(1'b1,1'b0,1'b0,28'd0,E_RN);  add(1'b1,1'b0,1'b0,28'd0,E_RN);
    add(1'b0,1'b0,1'b0,28'd0,E_RN);  add(1'b0,1'b0,1'b0,28'd0,E_0);

    @(negedge clk);
    check("reset_outputs", {27'd0, obs()}, {27'd0, E_0});
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      run = vecs[i].run; step = vecs[i].step;
      div_load = vecs[i].ld; div_value = vecs[i].val;
      cyc();
      check($sformatf("vec%0d", i + 1), {27'd0, obs()}, {27'd0, vecs[i].exp});
    end
    div_load = 1'b0; div_value = 28'd0;

    // reset mid-run (DIV=8, counter 2) with a load of 9 pending
    run = 1'b1;
    cyc();
    div_load = 1'b1; div_value = 28'd9;
    cyc();
    div_load = 1'b0; div_value = 28'd0;
    cyc();
    check("pre_reset_running", {31'd0, running}, 32'd1);
    #2 reset_n = 1'b0;
    #1 check("async_reset_outputs", {27'd0, obs()}, {27'd0, E_0});
    @(negedge clk);
    reset_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      cyc();
      check($sformatf("post_reset_c%0d", k), {27'd0, obs()},
            {27'd0, ((k % 4) == 0) ? E_RD : (((k % 4) == 2) ? E_WR : E_RN)});
    end
    run = 1'b0;
    for (int i = 0; i < 20 && running; i++) cyc();
    check("halt_after_run", {31'd0, running}, 32'd0);

    // single step holds running for exactly div (4) cycles
    step = 1'b1;
    cyc();
    step = 1'b0;
    cnt = 0;
    for (int i = 0; i < 20 && running; i++) begin
      cnt++;
      cyc();
    end
    check("step_running_cycles", cnt, 32'd4);
    check("step_halted", {31'd0, running}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/clock_step_controller.md
# clock_step_controller

Run/halt/single-step scheduler for the processor clock divider. It counts the fast input clock and emits one-cycle `tick_read` and `tick_write` strobes, once each per processor cycle, with a runtime-programmable period. The processor datapath uses these strobes as clock enables for its read and write phases. The block sits between the board clock/debug controls and the core, replacing a fixed divide ratio with a controllable one.

## Interface
Parameters:
- `WIDTH`, 28: counter and divisor width in bits.
- `DEFAULT_DIV`, 4: divisor loaded at reset; must be ≥2.

Ports:
- `clock_in`, in, 1: single clock for all logic; rising-edge triggered.
- `reset_n`, in, 1: asynchronous, active-low reset.
- `run`, in, 1: level; 1 requests free-running processor cycles.
- `step`, in, 1: level, rising-edge detected internally; requests exactly one processor cycle.
- `div_load`, in, 1: one-cycle request to change the divisor.
- `div_value`, in, WIDTH: new divisor; sampled when `div_load`=1.
- `div_ack`, out, 1: one-cycle pulse after a new divisor takes effect.
- `div_err`, out, 1: one-cycle pulse after a rejected load (`div_value` < 2).
- `tick_read`, out, 1: read-phase strobe, one cycle per processor cycle.
- `tick_write`, out, 1: write-phase strobe, one cycle per processor cycle.
- `running`, out, 1: 1 whenever state ≠ HALT.

## Operation
- State register: HALT=0, RUN=1, STEP=2. Also holds `counter[WIDTH-1:0]`, `div`, `pend_div`, `pend_valid` and `step_q`.
- Reset values: state HALT, `counter`=0, `div`=DEFAULT_DIV, `pend_valid`=0, `step_q`=0. All outputs are 0.
- Step edge detection: `step_edge` = `step` & ~`step_q`. `step_q` <= `step` every cycle.
- HALT:
  - `counter` is held at 0 and no strobes are emitted.
  - `run`=1 → RUN.
  - Otherwise, `step_edge` → STEP.
  - `run` has priority when it coincides with a step edge.
- RUN:
  - `counter` increments each cycle.
  - At `counter`==`div`-1 it wraps to 0 (the period boundary).
  - At the boundary, if `run`=0 → HALT. Otherwise stay in RUN.
  - Deasserting `run` mid-period never truncates the period.
- STEP:
  - Counts exactly like RUN.
  - At the boundary → HALT unconditionally.
  - `run` and `step_edge` are ignored in STEP.
  - `step_edge` is also ignored in RUN.
- Strobe decode (combinational from registered state and counter):
  - `tick_read` = (state≠HALT) & (`counter`==0).
  - `tick_write` = (state≠HALT) & (`counter`==`div`>>1). The shift uses floor.
  - Since `div`≥2, the two strobes never coincide.
- Divisor load:
  - `div_load` with `div_value`<2: no state change; `div_err`=1 in the next cycle.
  - `div_load` with `div_value`≥2: `pend_div`<=`div_value`, `pend_valid`<=1. A later valid load overwrites an unapplied one (last wins).
  - Apply point: `div`<=`pend_div`, `pend_valid`<=0, `div_ack`=1 in the next cycle. Apply happens:
    - at the edge where the block is in HALT, or
    - at a period-boundary edge in RUN/STEP.
  - Divisor changes never occur mid-period.
  - A valid `div_load` in the same cycle as an apply: the older pending value is applied and acked. The new value becomes pending and is applied at the next apply point.
- Arithmetic: `counter` is unsigned, WIDTH bits. It never exceeds `div`-1, so no overflow is possible. Divisor range is 2 .. 2^WIDTH-1.

## Timing
- Cycle numbering: the cycle after the sampling edge is N+1.
- Start latency: `run` or a step edge sampled at edge N → state RUN/STEP, `counter`=0, `running`=1 and `tick_read`=1 in cycle N+1.
- Within each period, `tick_write` comes `div`>>1 cycles after `tick_read`.
- Period length is `div` cycles.
- STEP holds `running`=1 for exactly `div` cycles.
- `div_err`, `div_ack`: registered, exactly one cycle wide.
- Reset mid-operation: asserting `reset_n`=0 immediately forces all outputs low and all state to reset values. A pending divisor is discarded. Release is synchronous to the next edge.

## Test plan
- Reset, then `run`=1 held, DIV=4 → `tick_read` in cycles 1,5,9; `tick_write` in cycles 3,7,11; `running`=1 from cycle 1.
- HALT, single `step` pulse, DIV=4 → one `tick_read` (cycle 1) and one `tick_write` (cycle 3); `running` high for cycles 1-4. A second `step` edge at cycle 2 is ignored.
- RUN with DIV=4, load 6 at `counter`=1 → current period stays 4 cycles; `div_ack` pulses in the cycle after the wrap; following `tick_read`s are 6 cycles apart, `tick_write` at `counter`=3.
- Load `div_value`=1 and `div_value`=0 → `div_err` pulses one cycle later; period unchanged; no `div_ack`.
- DIV=5, `run` dropped at `counter`=2 → `tick_write` at `counter`=2; period completes through `counter`=4; then HALT with `running`=0 and no further strobes.
- `reset_n` low at `counter`=2 during RUN with a load pending → all outputs 0 the same cycle. After release, DIV=DEFAULT_DIV and no `div_ack`.
